// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-vector layout, stage shadow record,
// forwarding selects and the data-memory handshake states.
package pipe_pkg;

  localparam int ARCH_REGS            = 32;
  localparam int REG_W                = $clog2(ARCH_REGS);
  localparam int CONTR_SIG_SIZE       = 5;
  localparam int CONTR_VALID_INDEX    = 0;
  localparam int CONTR_REGWRITE_INDEX = 1;
  localparam int CONTR_MEMRE_INDEX    = 3;
  localparam int CONTR_MEMWR_INDEX    = 4;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             valid;
    logic             regwrite;
    logic             memre;
    logic             memwr;
  } stage_t;

  // x0 is hardwired, so a stage targeting it never produces a usable value.
  function automatic logic is_writer(stage_t s);
    return s.valid && s.regwrite && (s.rd != '0);
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// Selects the EX operand source for one register index from the MEM and WB
// stage shadows; the nearer stage wins.
module fwd_unit
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  stage_t           mem_stage,
  input  stage_t           wb_stage,
  output fwd_sel_t         sel
);

  // A load in MEM has no data yet; the load-use bubble keeps that case from arising.
  always_comb begin
    sel = FWD_RF;
    if (src != '0) begin
      if (is_writer(mem_stage) && !mem_stage.memre && (mem_stage.rd == src))
        sel = FWD_MEM;
      else if (is_writer(wb_stage) && (wb_stage.rd == src))
        sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadows EX/MEM/WB, drives stage enables and
// bubbles, EX forwarding selects and the data-memory request handshake.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int NUM_A_REGS = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [$clog2(NUM_A_REGS)-1:0] id_rd_i,
  input  logic [$clog2(NUM_A_REGS)-1:0] id_rs1_i,
  input  logic [$clog2(NUM_A_REGS)-1:0] id_rs2_i,
  input  logic [CONTR_SIG_SIZE-1:0]     id_control_i,
  input  logic                          dmem_ready_i,
  output logic                          dmem_req_o,
  output logic                          pc_en_o,
  output logic                          if_id_en_o,
  output logic                          id_ex_en_o,
  output logic                          ex_mem_en_o,
  output logic                          id_ex_bubble_o,
  output logic                          mem_wb_bubble_o,
  output logic [1:0]                    fwd_a_o,
  output logic [1:0]                    fwd_b_o,
  output logic [CNT_WIDTH-1:0]          stall_cnt_o
);

  stage_t     id_entry, ex_q, mem_q, wb_q, mem_nxt;
  mem_state_t state_q, state_nxt;
  logic       req_q, req_nxt;
  logic       mem_access, mem_stall, load_use;
  fwd_sel_t   fwd_a, fwd_b;

  always_comb begin
    id_entry          = '0;
    id_entry.rd       = id_rd_i;
    id_entry.rs1      = id_rs1_i;
    id_entry.rs2      = id_rs2_i;
    id_entry.valid    = id_control_i[CONTR_VALID_INDEX];
    id_entry.regwrite = id_control_i[CONTR_REGWRITE_INDEX];
    id_entry.memre    = id_control_i[CONTR_MEMRE_INDEX];
    id_entry.memwr    = id_control_i[CONTR_MEMWR_INDEX];
  end

  assign mem_access = mem_q.valid && (mem_q.memre || mem_q.memwr);
  assign mem_stall  = req_q && !dmem_ready_i;
  assign load_use   = !mem_stall && ex_q.valid && ex_q.memre && (ex_q.rd != '0) &&
                      id_entry.valid && ((ex_q.rd == id_rs1_i) || (ex_q.rd == id_rs2_i));

  assign pc_en_o         = !mem_stall && !load_use;
  assign if_id_en_o      = !mem_stall && !load_use;
  assign id_ex_en_o      = !mem_stall;
  assign ex_mem_en_o     = !mem_stall;
  assign id_ex_bubble_o  = load_use;
  assign mem_wb_bubble_o = mem_stall;
  assign dmem_req_o      = req_q;

  // The request is registered by predicting next cycle's MEM occupant and state.
  always_comb begin
    mem_nxt   = mem_stall ? mem_q : ex_q;
    state_nxt = state_q;
    case (state_q)
      RUN:     if (mem_access && !dmem_ready_i) state_nxt = WAIT;
      WAIT:    if (dmem_ready_i) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
    req_nxt = (state_nxt == WAIT) || (mem_nxt.valid && (mem_nxt.memre || mem_nxt.memwr));
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      state_q     <= RUN;
      req_q       <= 1'b0;
      stall_cnt_o <= '0;
    end else begin
      state_q <= state_nxt;
      req_q   <= req_nxt;
      if (mem_stall) begin
        wb_q <= '0;
      end else begin
        ex_q  <= load_use ? '0 : id_entry;
        mem_q <= ex_q;
        wb_q  <= mem_q;
      end
      if (!pc_en_o && (stall_cnt_o != '1))
        stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

  fwd_unit u_fwd_a (.src(ex_q.rs1), .mem_stage(mem_q), .wb_stage(wb_q), .sel(fwd_a));
  fwd_unit u_fwd_b (.src(ex_q.rs2), .mem_stage(mem_q), .wb_stage(wb_q), .sel(fwd_b));

  assign fwd_a_o = fwd_a;
  assign fwd_b_o = fwd_b;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: each driven cycle queues its expected
// control outputs, which the negedge monitor pops and compares.
module tb_hazard_ctrl;

  localparam logic [4:0] NOP = 5'b00000;
  localparam logic [4:0] ALU = 5'b00011;
  localparam logic [4:0] LW  = 5'b01011;
  localparam logic [4:0] SW  = 5'b10001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rd, id_rs1, id_rs2, id_ctrl;
  logic        dmem_ready;
  logic        dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, id_ex_bubble, mem_wb_bubble;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] stall_cnt;
  logic [10:0] obs;

  typedef struct {
    string       tag;
    logic [10:0] flags;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  hazard_ctrl #(.NUM_A_REGS(32), .CNT_WIDTH(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .id_rd_i(id_rd), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_control_i(id_ctrl),
    .dmem_ready_i(dmem_ready), .dmem_req_o(dmem_req),
    .pc_en_o(pc_en), .if_id_en_o(if_id_en), .id_ex_en_o(id_ex_en), .ex_mem_en_o(ex_mem_en),
    .id_ex_bubble_o(id_ex_bubble), .mem_wb_bubble_o(mem_wb_bubble),
    .fwd_a_o(fwd_a), .fwd_b_o(fwd_b), .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  assign obs = {pc_en, if_id_en, id_ex_en, ex_mem_en, id_ex_bubble, mem_wb_bubble,
                fwd_a, fwd_b, dmem_req};

  function automatic logic [10:0] nrm(logic [1:0] fa, logic [1:0] fb, logic rq);
    return {4'b1111, 2'b00, fa, fb, rq};
  endfunction

  function automatic logic [10:0] mst(logic [1:0] fa, logic [1:0] fb);
    return {4'b0000, 2'b01, fa, fb, 1'b1};
  endfunction

  function automatic logic [10:0] luse(logic [1:0] fa, logic [1:0] fb, logic rq);
    return {4'b0011, 2'b10, fa, fb, rq};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  // Called just after a rising edge; the cycle's expectation is checked at the following negedge.
  task automatic applyStimulus(input string tag, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [4:0] ctrl, input logic rdy,
                               input logic [10:0] flags, input logic [31:0] cnt);
    exp_t e;
    id_rd = rd; id_rs1 = rs1; id_rs2 = rs2; id_ctrl = ctrl; dmem_ready = rdy;
    e.tag = tag; e.flags = flags; e.cnt = cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      checkOutput({mon_e.tag, "_ctl"}, 32'(obs), 32'(mon_e.flags));
      checkOutput({mon_e.tag, "_cnt"}, stall_cnt, mon_e.cnt);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; id_rd = '0; id_rs1 = '0; id_rs2 = '0; id_ctrl = '0; dmem_ready = 1'b1;
    #2;
    checkOutput("reset_ctl", 32'(obs), 32'(nrm(2'b00, 2'b00, 1'b0)));
    checkOutput("reset_cnt", stall_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // add x1,x2,x3 ; add x4,x1,x1 -> both operands from EX/MEM
    applyStimulus("s1_add1", 5'd1, 5'd2, 5'd3, ALU, 1'b1, nrm(2'b00, 2'b00, 1'b0), 0);
    applyStimulus("s1_add2", 5'd4, 5'd1, 5'd1, ALU, 1'b1, nrm(2'b00, 2'b00, 1'b0), 0);
    applyStimulus("s1_fwd",  5'd0, 5'd0, 5'd0, NOP, 1'b1, nrm(2'b01, 2'b01, 1'b0), 0);
    for (int i = 0; i < 2; i++)
      applyStimulus("s1_flush", 5'd0, 5'd0, 5'd0, NOP, 1'b1, nrm(2'b00, 2'b00, 1'b0), 0);

    // x1 written by both MEM and WB: the younger MEM value must win
    applyStimulus("pr_a",   5'd1, 5'd2, 5'd3, ALU, 1'b1, nrm(2'b00, 2'b00, 1'b0), 0);
    applyStimulus("pr_b",   5'd1, 5'd4, 5'd4, ALU, 1'b1, nrm(2'b00, 2'b00, 1'b0), 0);
    applyStimulus("pr_c",   5'd9, 5'd1, 5'd1, ALU, 1'b1, nrm(2'b00, 2'b00, 1'b0), 0);
    applyStimulus("pr_fwd", 5'd0, 5'd0, 5'd0, NOP, 1'b1, nrm(2'b01, 2'b01, 1'b0), 0);
    for (int i = 0; i < 2; i++)
      applyStimulus("pr_flush", 5'd0, 5'd0, 5'd0, NOP, 1'b1, nrm(2'b00, 2'b00, 1'b0), 0);

    // lw x5 ; add x6,x5,x0 -> one bubble, then WB forwarding on rs1
    applyStimulus("s2_lw",    5'd5, 5'd2, 5'd0, LW,  1'b1, nrm(2'b00, 2'b00, 1'b0), 0);
    applyStimulus("s2_luse",  5'd6, 5'd5, 5'd0, ALU, 1'b1, luse(2'b00, 2'b00, 1'b0), 0);
    applyStimulus("s2_retry", 5'd6, 5'd5, 5'd0, ALU, 1'b1, nrm(2'b00, 2'b00, 1'b1), 1);
    applyStimulus("s2_fwd",   5'd0, 5'd0, 5'd0, NOP, 1'b1, nrm(2'b10, 2'b00, 1'b0), 1);
    for (int i = 0; i < 2; i++)
      applyStimulus("s2_flush", 5'd0, 5'd0, 5'd0, NOP, 1'b1, nrm(2'b00, 2'b00, 1'b0), 1);

    // sw x7 with three wait cycles
    applyStimulus("s3_sw",  5'd0, 5'd2, 5'd7, SW,  1'b1, nrm(2'b00, 2'b00, 1'b0), 1);
    applyStimulus("s3_ex",  5'd0, 5'd0, 5'd0, NOP, 1'b1, nrm(2'b00, 2'b00, 1'b0), 1);
    for (int i = 0; i < 3; i++)
      applyStimulus("s3_wait", 5'd0, 5'd0, 5'd0, NOP, 1'b0, mst(2'b00, 2'b00), 32'(1 + i));
    applyStimulus("s3_done", 5'd0, 5'd0, 5'd0, NOP, 1'b1, nrm(2'b00, 2'b00, 1'b1), 4);
    applyStimulus("s3_idle", 5'd0, 5'd0, 5'd0, NOP, 1'b1, nrm(2'b00, 2'b00, 1'b0), 4);

    // addi x0,x1,5 ; add x8,x0,x0 -> register 0 never forwards
    applyStimulus("s4_addi", 5'd0, 5'd1, 5'd0, ALU, 1'b1, nrm(2'b00, 2'b00, 1'b0), 4);
    applyStimulus("s4_add",  5'd8, 5'd0, 5'd0, ALU, 1'b1, nrm(2'b00, 2'b00, 1'b0), 4);
    applyStimulus("s4_memx0", 5'd0, 5'd0, 5'd0, NOP, 1'b1, nrm(2'b00, 2'b00, 1'b0), 4);
    for (int i = 0; i < 2; i++)
      applyStimulus("s4_flush", 5'd0, 5'd0, 5'd0, NOP, 1'b1, nrm(2'b00, 2'b00, 1'b0), 4);

    // sw waits 2 cycles while a load-use pair is pending behind it
    applyStimulus("s5_sw",   5'd0, 5'd2, 5'd7, SW,  1'b1, nrm(2'b00, 2'b00, 1'b0), 4);
    applyStimulus("s5_lw",   5'd5, 5'd2, 5'd0, LW,  1'b1, nrm(2'b00, 2'b00, 1'b0), 4);
    applyStimulus("s5_w1",   5'd6, 5'd5, 5'd0, ALU, 1'b0, mst(2'b00, 2'b00), 4);
    applyStimulus("s5_w2",   5'd6, 5'd5, 5'd0, ALU, 1'b0, mst(2'b00, 2'b00), 5);
    applyStimulus("s5_luse", 5'd6, 5'd5, 5'd0, ALU, 1'b1, luse(2'b00, 2'b00, 1'b1), 6);
    applyStimulus("s5_go",   5'd6, 5'd5, 5'd0, ALU, 1'b1, nrm(2'b00, 2'b00, 1'b1), 7);
    applyStimulus("s5_fwd",  5'd0, 5'd0, 5'd0, NOP, 1'b1, nrm(2'b10, 2'b00, 1'b0), 7);
    for (int i = 0; i < 2; i++)
      applyStimulus("s5_flush", 5'd0, 5'd0, 5'd0, NOP, 1'b1, nrm(2'b00, 2'b00, 1'b0), 7);

    // asynchronous reset while the FSM is waiting on memory
    applyStimulus("s6_sw",   5'd0, 5'd2, 5'd7, SW,  1'b1, nrm(2'b00, 2'b00, 1'b0), 7);
    applyStimulus("s6_ex",   5'd0, 5'd0, 5'd0, NOP, 1'b1, nrm(2'b00, 2'b00, 1'b0), 7);
    applyStimulus("s6_wait", 5'd0, 5'd0, 5'd0, NOP, 1'b0, mst(2'b00, 2'b00), 7);
    dmem_ready = 1'b0;
    #1;
    checkOutput("s6_prereset_ctl", 32'(obs), 32'(mst(2'b00, 2'b00)));
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("s6_rst_ctl", 32'(obs), 32'(nrm(2'b00, 2'b00, 1'b0)));
    checkOutput("s6_rst_cnt", stall_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus("s6_run", 5'd0, 5'd0, 5'd0, NOP, 1'b0, nrm(2'b00, 2'b00, 1'b0), 0);
    applyStimulus("s6_end", 5'd0, 5'd0, 5'd0, NOP, 1'b1, nrm(2'b00, 2'b00, 1'b0), 0);

    @(negedge clk);
    checkOutput("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline controller for the 5-stage core; sits beside decode_stage and observes its rd/rs1/rs2/control outputs.
- Tracks the destination and control state of the EX, MEM and WB stages in shadow registers.
- Generates stage enables, bubble insertion and EX operand-forwarding selects.
- Sequences the data-memory request/ready handshake for LW/SW.

Parameters:
- NUM_A_REGS, 32, architectural register count; register index width is $clog2(NUM_A_REGS).
- CONTR_SIG_SIZE, 5, width of the decode control vector.
- CONTR_VALID_INDEX / CONTR_REGWRITE_INDEX / CONTR_MEMRE_INDEX / CONTR_MEMWR_INDEX, 0/1/3/4, bit positions in the control vector.
- CNT_WIDTH, 32, width of the stall-cycle counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- id_rd_i / id_rs1_i / id_rs2_i  in  $clog2(NUM_A_REGS) each  decode register fields; unused fields arrive as 0.
- id_control_i  in  CONTR_SIG_SIZE  decode control vector.
- dmem_ready_i  in  1  data-memory access completes this cycle.
- dmem_req_o  out  1  MEM-stage access pending.
- pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o  out  1 each  pipeline register load enables.
- id_ex_bubble_o  out  1  load an invalid (all-zero control) entry into ID/EX.
- mem_wb_bubble_o  out  1  load an invalid entry into MEM/WB.
- fwd_a_o, fwd_b_o  out  2 each  EX operand source: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB writeback value.
- stall_cnt_o  out  CNT_WIDTH  saturating count of stalled cycles.

Behaviour:
- Clocking: one clock; rst_n_i asynchronous active-low.
- Reset: all shadow entries invalid; FSM = RUN; stall_cnt_o = 0.
  - Outputs at reset: enables = 1, bubbles = 0, fwd = 00, dmem_req_o = 0.
- Shadows: EX, MEM and WB each hold {rd, rs1, rs2 (EX only), valid, regwrite, memre, memwr}.
- An entry is a "writer" when valid && regwrite && rd != 0.
- mem_access = MEM.valid && (MEM.memre || MEM.memwr).
- FSM RUN:
  - dmem_req_o = mem_access.
  - If mem_access && !dmem_ready_i, go to WAIT.
- FSM WAIT:
  - dmem_req_o = 1.
  - When dmem_ready_i = 1, go to RUN; the access completes that cycle.
  - Zero-wait access completes in the request cycle.
- mem_stall = dmem_req_o && !dmem_ready_i.
  - All enables = 0; mem_wb_bubble_o = 1; id_ex_bubble_o = 0.
  - EX and MEM shadows hold; WB shadow is invalidated.
- load_use = !mem_stall && EX.valid && EX.memre && EX.rd != 0 && id_control_i valid && (EX.rd == id_rs1_i || EX.rd == id_rs2_i).
  - pc_en_o = if_id_en_o = 0; id_ex_bubble_o = 1; ex_mem_en_o = 1.
  - EX shadow becomes invalid; MEM and WB shadows advance.
  - Lasts exactly 1 cycle.
- Normal cycle: all enables = 1.
  - EX <= ID; bits are captured regardless of valid, and an invalid ID entry never causes a hazard.
  - MEM <= EX; WB <= MEM.
- Priority: mem_stall over load_use. A load-use pair present during a memory wait resolves after the wait ends.
- Forwarding (combinational from shadows), fwd_a_o for EX.rs1 and fwd_b_o for EX.rs2:
  - 01 if MEM is a writer && !MEM.memre && MEM.rd matches.
  - else 10 if WB is a writer && WB.rd matches.
  - else 00.
  - Index 0 never matches.
  - MEM-stage load matching an EX source is unreachable because load_use inserts a bubble; forward 00 in that case.
- No ID-stage bypass: the register file is write-through.
- stall_cnt_o: +1 in each cycle where pc_en_o = 0; saturates at all-ones.
- Reset mid-WAIT: immediate return to reset values; the outstanding access is abandoned.

Decomposition:
- Shared package pipe_pkg holds:
  - control bit indices and CONTR_SIG_SIZE;
  - fwd_sel_t enum {FWD_RF = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10};
  - a stage-shadow struct typedef;
  - FSM state enum {RUN, WAIT}.
- One sub-module is natural: fwd_unit, the combinational forward selection, instantiated once per operand.

Test Plan:
- add x1,x2,x3 then add x4,x1,x1 back-to-back -> consumer in EX sees fwd_a_o = fwd_b_o = 01; no stall; stall_cnt_o stays 0.
- lw x5,0(x2) then add x6,x5,x0 with dmem_ready_i tied high -> one cycle of pc_en_o = if_id_en_o = 0 and id_ex_bubble_o = 1; next cycle fwd_a_o = 10, fwd_b_o = 00; stall_cnt_o = 1.
- sw x7,4(x2) with dmem_ready_i low 3 cycles then high -> FSM WAIT; dmem_req_o high 4 cycles; all enables 0 and mem_wb_bubble_o = 1 for 3 cycles; stall_cnt_o += 3.
- addi x0,x1,5 then add x8,x0,x0 -> fwd 00 on both operands; no stall.
- lw x5 in EX with dependent instruction in ID, while an earlier sw in MEM waits 2 cycles -> 2 mem-stall cycles, then exactly 1 load-use bubble, then fwd_a_o = 10.
- rst_n_i pulsed low during WAIT without a clock edge -> outputs return to reset values immediately; FSM RUN; stall_cnt_o = 0.
